// File: rtl/jtframe_dwnld_banks.sv
// jtframe_dwnld_banks: turns the 8-bit ioctl download stream into 16-bit SDRAM
// programming writes over four banks. A byte FIFO decouples ioctl from SDRAM,
// and bytes at or above PROM_START go to a separate PROM strobe port.
// Optional header skip is enabled by defining JTFRAME_DWNLD_HEADER_EN.
module jtframe_dwnld_banks #(
    parameter logic [24:0] BA1_START  = 25'h10_0000,
    parameter logic [24:0] BA2_START  = 25'h18_0000,
    parameter logic [24:0] BA3_START  = 25'h1C_0000,
    parameter logic [24:0] PROM_START = 25'h1F_0000,
    parameter int          SWAB       = 0,
    parameter int          DEPTH      = 4,
    parameter int          HEADER_LEN = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        downloading,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_data,
    input  logic        ioctl_wr,
    output logic [21:0] prog_addr,
    output logic [15:0] prog_data,
    output logic [1:0]  prog_mask,
    output logic [1:0]  prog_ba,
    output logic        prog_we,
    input  logic        prog_rdy,
    output logic        prom_we,
    output logic [15:0] prom_addr,
    output logic [7:0]  prom_data,
    output logic        dwnld_busy,
    output logic        overflow
`ifdef JTFRAME_DWNLD_HEADER_EN
    ,
    output logic        header_we,
    output logic [7:0]  header_addr
`endif
);
    localparam int   AW       = $clog2(DEPTH);
    localparam logic SWAB_BIT = (SWAB != 0);

    typedef struct packed {
        logic [21:0] addr;
        logic [1:0]  mask;
        logic [1:0]  ba;
        logic [7:0]  data;
    } entry_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    logic [24:0] eff_addr_s;
    logic [24:0] start_s;
    logic [22:0] off_s;
    logic [15:0] prom_off_s;
    logic [1:0]  ba_s;
    logic [1:0]  mask_s;
    logic        hdr_s;
    logic        prom_s;
    logic        wr_ok_s;
    logic        push_s;
    logic        push_ok_s;
    logic        pop_s;
    logic        full_s;
    logic [AW:0] count_next_s;
    entry_t      new_s;

    entry_t      mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    state_t        state_r;
    entry_t        cur_r;
    logic          prog_we_r;
    logic          prom_we_r;
    logic [15:0]   prom_addr_r;
    logic [7:0]    prom_data_r;
    logic          busy_r;
    logic          overflow_r;

    // Address decode: header skip, bank selection, offset and byte-lane mask
    always_comb begin
        eff_addr_s = ioctl_addr;
        hdr_s      = 1'b0;
`ifdef JTFRAME_DWNLD_HEADER_EN
        hdr_s      = (ioctl_addr < 25'(HEADER_LEN));
        eff_addr_s = ioctl_addr - 25'(HEADER_LEN);
`endif
        if (eff_addr_s >= BA3_START) begin
            ba_s    = 2'd3;
            start_s = BA3_START;
        end else if (eff_addr_s >= BA2_START) begin
            ba_s    = 2'd2;
            start_s = BA2_START;
        end else if (eff_addr_s >= BA1_START) begin
            ba_s    = 2'd1;
            start_s = BA1_START;
        end else begin
            ba_s    = 2'd0;
            start_s = 25'd0;
        end
        off_s      = 23'(eff_addr_s - start_s);
        prom_off_s = 16'(eff_addr_s - PROM_START);
        mask_s     = (off_s[0] ^ SWAB_BIT) ? 2'b01 : 2'b10;
        prom_s     = (eff_addr_s >= PROM_START);
        new_s      = '{addr: off_s[22:1], mask: mask_s, ba: ba_s, data: ioctl_data};
    end

    // Push/pop qualification; a pop in the same cycle frees a slot for a push
    always_comb begin
        wr_ok_s   = ioctl_wr & downloading & ~hdr_s;
        push_s    = wr_ok_s & ~prom_s;
        pop_s     = (state_r == ST_IDLE) && (count_r != '0);
        full_s    = (count_r == (AW+1)'(DEPTH));
        push_ok_s = push_s & (~full_s | pop_s);
        if (push_ok_s && !pop_s) begin
            count_next_s = count_r + (AW+1)'(1);
        end else if (!push_ok_s && pop_s) begin
            count_next_s = count_r - (AW+1)'(1);
        end else begin
            count_next_s = count_r;
        end
    end

    // Byte FIFO storage, pointers and sticky overflow flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= '0;
            overflow_r <= 1'b0;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= new_s;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            if (push_s && !push_ok_s) begin
                overflow_r <= 1'b1;
            end
            count_r <= count_next_s;
        end
    end

    // SDRAM write FSM: load head, hold until prog_rdy, then one idle gap cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            cur_r     <= '0;
            prog_we_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pop_s) begin
                        cur_r     <= mem_r[rd_ptr_r];
                        prog_we_r <= 1'b1;
                        state_r   <= ST_WAIT;
                    end else begin
                        prog_we_r <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (prog_rdy) begin
                        prog_we_r <= 1'b0;
                        state_r   <= ST_GAP;
                    end else begin
                        prog_we_r <= 1'b1;
                    end
                end
                ST_GAP: begin
                    prog_we_r <= 1'b0;
                    state_r   <= ST_IDLE;
                end
                default: begin
                    prog_we_r <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

    // PROM bypass strobe and busy flag; busy looks at next FIFO/FSM state so
    // it drops in the first idle cycle after the final gap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prom_we_r   <= 1'b0;
            prom_addr_r <= 16'd0;
            prom_data_r <= 8'd0;
            busy_r      <= 1'b0;
        end else begin
            prom_we_r <= wr_ok_s & prom_s;
            if (wr_ok_s && prom_s) begin
                prom_addr_r <= prom_off_s;
                prom_data_r <= ioctl_data;
            end
            busy_r <= downloading | (count_next_s != '0) | pop_s | (state_r == ST_WAIT);
        end
    end

`ifdef JTFRAME_DWNLD_HEADER_EN
    logic       header_we_r;
    logic [7:0] header_addr_r;

    // Header byte strobe, raw low address byte
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            header_we_r   <= 1'b0;
            header_addr_r <= 8'd0;
        end else begin
            header_we_r <= ioctl_wr & downloading & hdr_s;
            if (ioctl_wr && downloading && hdr_s) begin
                header_addr_r <= ioctl_addr[7:0];
            end
        end
    end

    assign header_we   = header_we_r;
    assign header_addr = header_addr_r;
`endif

    assign prog_addr  = cur_r.addr;
    assign prog_data  = {cur_r.data, cur_r.data};
    assign prog_mask  = cur_r.mask;
    assign prog_ba    = cur_r.ba;
    assign prog_we    = prog_we_r;
    assign prom_we    = prom_we_r;
    assign prom_addr  = prom_addr_r;
    assign prom_data  = prom_data_r;
    assign dwnld_busy = busy_r;
    assign overflow   = overflow_r;

endmodule

// File: tb/tb_jtframe_dwnld_banks.sv
// Testbench for jtframe_dwnld_banks: vector table plus multi-cycle sequences,
// SDRAM/PROM writes checked against scoreboard queues.
module tb_jtframe_dwnld_banks;
`ifdef JTFRAME_DWNLD_HEADER_EN
    localparam logic [24:0] HDR = 25'd16;
`else
    localparam logic [24:0] HDR = 25'd0;
`endif

    typedef struct {
        logic [24:0] addr;
        logic [7:0]  data;
        logic        prom;
        logic [1:0]  ba;
        logic [21:0] paddr;
        logic [1:0]  mask;
        logic [15:0] poff;
    } vec_t;

    typedef struct {
        logic [1:0]  ba;
        logic [21:0] addr;
        logic [1:0]  mask;
        logic [15:0] data;
    } exp_t;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
    } pexp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        downloading = 1'b0;
    logic [24:0] ioctl_addr = 25'd0;
    logic [7:0]  ioctl_data = 8'd0;
    logic        ioctl_wr = 1'b0;
    logic [21:0] prog_addr, prog_addr1;
    logic [15:0] prog_data, prog_data1;
    logic [1:0]  prog_mask, prog_mask1;
    logic [1:0]  prog_ba, prog_ba1;
    logic        prog_we, prog_we1;
    logic        prog_rdy, prog_rdy1;
    logic        prom_we, prom_we1;
    logic [15:0] prom_addr, prom_addr1;
    logic [7:0]  prom_data, prom_data1;
    logic        dwnld_busy, dwnld_busy1;
    logic        overflow, overflow1;
`ifdef JTFRAME_DWNLD_HEADER_EN
    logic        header_we, header_we1;
    logic [7:0]  header_addr, header_addr1;
`endif

    int    checks = 0;
    int    errors = 0;
    logic  hold_rdy = 1'b0;
    logic  chk1 = 1'b1;
    int    rdy_cnt = 0;
    int    rdy_cnt1 = 0;
    exp_t  sb[$];
    exp_t  sb1[$];
    pexp_t pq[$];
    exp_t  cur;
    logic  have_cur = 1'b0;
    logic  we_prev = 1'b0;
    logic  we1_prev = 1'b0;
    logic  prom_prev = 1'b0;
    vec_t  vecs[10];

    always #5 clk = ~clk;

    jtframe_dwnld_banks #(.SWAB(0), .DEPTH(4), .HEADER_LEN(int'(HDR))) dut (
        .clk(clk), .rst_n(rst_n), .downloading(downloading),
        .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_wr(ioctl_wr),
        .prog_addr(prog_addr), .prog_data(prog_data), .prog_mask(prog_mask),
        .prog_ba(prog_ba), .prog_we(prog_we), .prog_rdy(prog_rdy),
        .prom_we(prom_we), .prom_addr(prom_addr), .prom_data(prom_data),
        .dwnld_busy(dwnld_busy), .overflow(overflow)
`ifdef JTFRAME_DWNLD_HEADER_EN
        , .header_we(header_we), .header_addr(header_addr)
`endif
    );

    jtframe_dwnld_banks #(.SWAB(1), .DEPTH(4), .HEADER_LEN(int'(HDR))) dut_swab (
        .clk(clk), .rst_n(rst_n), .downloading(downloading),
        .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_wr(ioctl_wr),
        .prog_addr(prog_addr1), .prog_data(prog_data1), .prog_mask(prog_mask1),
        .prog_ba(prog_ba1), .prog_we(prog_we1), .prog_rdy(prog_rdy1),
        .prom_we(prom_we1), .prom_addr(prom_addr1), .prom_data(prom_data1),
        .dwnld_busy(dwnld_busy1), .overflow(overflow1)
`ifdef JTFRAME_DWNLD_HEADER_EN
        , .header_we(header_we1), .header_addr(header_addr1)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // SDRAM responder: prog_rdy pulse two cycles into each write unless held
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prog_rdy <= 1'b0;
            rdy_cnt  <= 0;
        end else if (prog_we && !prog_rdy && !hold_rdy) begin
            if (rdy_cnt == 1) begin
                prog_rdy <= 1'b1;
                rdy_cnt  <= 0;
            end else begin
                rdy_cnt <= rdy_cnt + 1;
            end
        end else begin
            prog_rdy <= 1'b0;
            rdy_cnt  <= 0;
        end
    end

    // Responder for the swapped-lane instance, never held
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prog_rdy1 <= 1'b0;
            rdy_cnt1  <= 0;
        end else if (prog_we1 && !prog_rdy1) begin
            prog_rdy1 <= 1'b1;
        end else begin
            prog_rdy1 <= 1'b0;
        end
    end

    // Output monitor: pop expectations on each new write / PROM strobe
    always @(negedge clk) begin
        if (prog_we && !we_prev) begin
            chk("spurious_prog_we", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                cur = sb.pop_front();
                have_cur = 1'b1;
                chk("prog_ba", 32'(prog_ba), 32'(cur.ba));
                chk("prog_addr", 32'(prog_addr), 32'(cur.addr));
                chk("prog_mask", 32'(prog_mask), 32'(cur.mask));
                chk("prog_data", 32'(prog_data), 32'(cur.data));
            end
        end
        if (prog_we && prog_rdy && have_cur) begin
            chk("prog_addr_held", 32'(prog_addr), 32'(cur.addr));
            chk("prog_data_held", 32'(prog_data), 32'(cur.data));
        end
        we_prev = prog_we;
        if (prom_we) begin
            chk("prom_we_width", 32'(prom_prev), 32'd0);
            chk("spurious_prom_we", 32'(pq.size() != 0), 32'd1);
            if (pq.size() != 0) begin
                pexp_t p;
                p = pq.pop_front();
                chk("prom_addr", 32'(prom_addr), 32'(p.addr));
                chk("prom_data", 32'(prom_data), 32'(p.data));
            end
        end
        prom_prev = prom_we;
        if (chk1 && prog_we1 && !we1_prev) begin
            chk("swab_spurious_we", 32'(sb1.size() != 0), 32'd1);
            if (sb1.size() != 0) begin
                exp_t e;
                e = sb1.pop_front();
                chk("swab_mask", 32'(prog_mask1), 32'(e.mask));
                chk("swab_addr", 32'(prog_addr1), 32'(e.addr));
            end
        end
        we1_prev = prog_we1;
    end

    task automatic send(input logic [24:0] a, input logic [7:0] d);
        @(negedge clk);
        ioctl_addr = a;
        ioctl_data = d;
        ioctl_wr   = 1'b1;
        @(negedge clk);
        ioctl_wr   = 1'b0;
    endtask

    task automatic push_exp(input logic [1:0] ba, input logic [21:0] a,
                            input logic [1:0] m, input logic [7:0] d);
        exp_t e;
        e = '{ba: ba, addr: a, mask: m, data: {d, d}};
        sb.push_back(e);
    endtask

    task automatic wait_drain(input string name);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && pq.size() == 0 && (sb1.size() == 0 || !chk1) &&
                !prog_we && !prog_we1) begin
                ok = 1'b1;
                break;
            end
        end
        chk({name, "_drain_timeout"}, 32'(ok), 32'd1);
    endtask

    // Wait for the end of the final write, then check busy in GAP and just after
    task automatic last_gap(input string name);
        logic p;
        logic found;
        p = prog_we;
        found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!prog_we && p && sb.size() == 0) begin
                found = 1'b1;
                break;
            end
            p = prog_we;
        end
        chk({name, "_last_gap_seen"}, 32'(found), 32'd1);
        chk({name, "_busy_in_gap"}, 32'(dwnld_busy), 32'd1);
        @(negedge clk);
        chk({name, "_busy_after_gap"}, 32'(dwnld_busy), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{25'h000000, 8'h11, 1'b0, 2'd0, 22'h0,      2'b10, 16'h0};
        vecs[1] = '{25'h000001, 8'h22, 1'b0, 2'd0, 22'h0,      2'b01, 16'h0};
        vecs[2] = '{25'h180005, 8'hAB, 1'b0, 2'd2, 22'h2,      2'b01, 16'h0};
        vecs[3] = '{25'h1F0010, 8'h5A, 1'b1, 2'd0, 22'h0,      2'b00, 16'h0010};
        vecs[4] = '{25'h100002, 8'h33, 1'b0, 2'd1, 22'h1,      2'b10, 16'h0};
        vecs[5] = '{25'h1C0007, 8'h44, 1'b0, 2'd3, 22'h3,      2'b01, 16'h0};
        vecs[6] = '{25'h0FFFFF, 8'h55, 1'b0, 2'd0, 22'h7FFFF,  2'b01, 16'h0};
        vecs[7] = '{25'h1EFFFE, 8'h66, 1'b0, 2'd3, 22'h17FFF,  2'b10, 16'h0};
        vecs[8] = '{25'h1FFFFF, 8'h77, 1'b1, 2'd0, 22'h0,      2'b00, 16'hFFFF};
        vecs[9] = '{25'h17FFFF, 8'h88, 1'b0, 2'd1, 22'h3FFFF,  2'b01, 16'h0};

        // reset state
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_prog_we", 32'(prog_we), 32'd0);
        chk("rst_prog_addr", 32'(prog_addr), 32'd0);
        chk("rst_prog_mask", 32'(prog_mask), 32'd0);
        chk("rst_prom_we", 32'(prom_we), 32'd0);
        chk("rst_busy", 32'(dwnld_busy), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);

        // ignored while not downloading
        send(HDR + 25'h000040, 8'hEE);
        repeat (6) @(negedge clk);

        downloading = 1'b1;
        repeat (2) @(negedge clk);
        chk("busy_downloading", 32'(dwnld_busy), 32'd1);

        for (int i = 0; i < 10; i++) begin
            if (vecs[i].prom) begin
                pexp_t p;
                p = '{addr: vecs[i].poff, data: vecs[i].data};
                pq.push_back(p);
            end else begin
                exp_t e1;
                push_exp(vecs[i].ba, vecs[i].paddr, vecs[i].mask, vecs[i].data);
                e1 = '{ba: vecs[i].ba, addr: vecs[i].paddr,
                       mask: {vecs[i].mask[0], vecs[i].mask[1]}, data: 16'h0};
                sb1.push_back(e1);
            end
            send(HDR + vecs[i].addr, vecs[i].data);
            wait_drain("vec");
        end
        chk1 = 1'b0;

`ifdef JTFRAME_DWNLD_HEADER_EN
        // header bytes strobe header_we only
        send(25'h000005, 8'h99);
        chk("header_we", 32'(header_we), 32'd1);
        chk("header_addr", 32'(header_addr), 32'h05);
        @(negedge clk);
        chk("header_we_width", 32'(header_we), 32'd0);
        repeat (6) @(negedge clk);
        send(25'h000010, 8'h12);
        chk("header_we_data_byte", 32'(header_we), 32'd0);
        push_exp(2'd0, 22'h0, 2'b10, 8'h12);
        wait_drain("hdr");
`endif

        // overflow: prog_rdy held, 6 back-to-back bytes; the first is loaded
        // into WAIT, four fill the FIFO, the sixth is dropped
        hold_rdy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            push_exp(2'd0, 22'h80 + 22'(i / 2), (i % 2 == 1) ? 2'b01 : 2'b10, 8'hA0 + 8'(i));
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            ioctl_addr = HDR + 25'h000100 + 25'(i);
            ioctl_data = 8'hA0 + 8'(i);
            ioctl_wr   = 1'b1;
        end
        @(negedge clk);
        ioctl_wr = 1'b0;
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_we_held", 32'(prog_we), 32'd1);
        repeat (4) @(negedge clk);
        chk("ovf_we_still_held", 32'(prog_we), 32'd1);
        downloading = 1'b0;
        hold_rdy = 1'b0;
        last_gap("ovf");
        chk("ovf_queue_empty", 32'(sb.size()), 32'd0);

        // drop downloading with three bytes pending, then a stray write
        downloading = 1'b1;
        hold_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push_exp(2'd2, 22'h10 + 22'(i / 2), (i % 2 == 1) ? 2'b01 : 2'b10, 8'hC0 + 8'(i));
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            ioctl_addr = HDR + 25'h180020 + 25'(i);
            ioctl_data = 8'hC0 + 8'(i);
            ioctl_wr   = 1'b1;
        end
        @(negedge clk);
        ioctl_wr = 1'b0;
        downloading = 1'b0;
        send(HDR + 25'h180030, 8'hDD);
        chk("drop_busy_held", 32'(dwnld_busy), 32'd1);
        hold_rdy = 1'b0;
        last_gap("drop");
        chk("drop_ovf_sticky", 32'(overflow), 32'd1);
        repeat (8) @(negedge clk);
        chk("drop_stray_ignored", 32'(sb.size()), 32'd0);

        // reset in the middle of a write
        downloading = 1'b1;
        hold_rdy = 1'b1;
        push_exp(2'd1, 22'h8, 2'b10, 8'h3C);
        send(HDR + 25'h100010, 8'h3C);
        send(HDR + 25'h100011, 8'h3D);
        repeat (2) @(negedge clk);
        chk("rstmid_we_before", 32'(prog_we), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstmid_we_dropped", 32'(prog_we), 32'd0);
        chk("rstmid_ovf_cleared", 32'(overflow), 32'd0);
        downloading = 1'b0;
        hold_rdy = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("rstmid_fifo_discarded", 32'(dwnld_busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
